// File: rtl/pattern_tx.sv
// rtl/pattern_tx.sv - serial bit-pattern transmitter with inter-frame gap and looping
module pattern_tx #(
    parameter int W  = 42,
    parameter int LW = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [W-1:0]  pattern,
    input  logic [LW-1:0] len,
    input  logic [7:0]    gap,
    input  logic          loop,
    input  logic          stop,
    output logic          x,
    output logic          x_valid,
    output logic          busy,
    output logic          frame_done,
    output logic          err,
    output logic [7:0]    frame_cnt
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] GAP  = 2'd1;
    localparam logic [1:0] SEND = 2'd2;

    logic [1:0]    state;
    logic [W-1:0]  pattern_r;
    logic [LW-1:0] len_r;
    logic [LW-1:0] idx;
    logic [7:0]    gap_r;
    logic [7:0]    gap_cnt;
    logic          loop_r;

    logic          len_ok;
    logic          loop_next;
    logic [LW-1:0] len_top;
    logic [LW-1:0] len_r_top;

    assign len_ok    = (len != '0) && (len <= LW'(W));
    assign len_top   = len - LW'(1);
    assign len_r_top = len_r - LW'(1);
    // A stop arriving on the last bit still has to end the loop.
    assign loop_next = loop_r & ~stop;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            pattern_r  <= '0;
            len_r      <= '0;
            idx        <= '0;
            gap_r      <= '0;
            gap_cnt    <= '0;
            loop_r     <= 1'b0;
            x          <= 1'b0;
            x_valid    <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            err        <= 1'b0;
            frame_cnt  <= '0;
        end else begin
            err <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (len_ok) begin
                            pattern_r <= pattern;
                            len_r     <= len;
                            gap_r     <= gap;
                            loop_r    <= loop;
                            frame_cnt <= '0;
                            busy      <= 1'b1;
                            if (gap != 8'd0) begin
                                state   <= GAP;
                                gap_cnt <= gap;
                            end else begin
                                state      <= SEND;
                                idx        <= len_top;
                                x          <= pattern[len_top];
                                x_valid    <= 1'b1;
                                frame_done <= (len == LW'(1));
                            end
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                GAP: begin
                    if (stop)
                        loop_r <= 1'b0;
                    if (gap_cnt == 8'd1) begin
                        state      <= SEND;
                        idx        <= len_r_top;
                        x          <= pattern_r[len_r_top];
                        x_valid    <= 1'b1;
                        frame_done <= (len_r == LW'(1));
                    end else begin
                        gap_cnt <= gap_cnt - 8'd1;
                    end
                end
                SEND: begin
                    if (stop)
                        loop_r <= 1'b0;
                    if (idx == '0) begin
                        frame_cnt <= frame_cnt + 8'd1;
                        if (loop_next && gap_r != 8'd0) begin
                            state      <= GAP;
                            gap_cnt    <= gap_r;
                            x          <= 1'b0;
                            x_valid    <= 1'b0;
                            frame_done <= 1'b0;
                        end else if (loop_next) begin
                            idx        <= len_r_top;
                            x          <= pattern_r[len_r_top];
                            frame_done <= (len_r == LW'(1));
                        end else begin
                            state      <= IDLE;
                            x          <= 1'b0;
                            x_valid    <= 1'b0;
                            busy       <= 1'b0;
                            frame_done <= 1'b0;
                        end
                    end else begin
                        idx        <= idx - LW'(1);
                        x          <= pattern_r[idx - LW'(1)];
                        frame_done <= (idx == LW'(1));
                    end
                end
                default: begin
                    state      <= IDLE;
                    x          <= 1'b0;
                    x_valid    <= 1'b0;
                    busy       <= 1'b0;
                    frame_done <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pattern_tx.sv
// tb/tb_pattern_tx.sv - directed self-checking bench for pattern_tx
module tb_pattern_tx;

    localparam int W  = 42;
    localparam int LW = 6;

    logic          clk;
    logic          rst;
    logic          start;
    logic [W-1:0]  pattern;
    logic [LW-1:0] len;
    logic [7:0]    gap;
    logic          loop;
    logic          stop;
    logic          x;
    logic          x_valid;
    logic          busy;
    logic          frame_done;
    logic          err;
    logic [7:0]    frame_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    pattern_tx #(.W(W), .LW(LW)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .pattern    (pattern),
        .len        (len),
        .gap        (gap),
        .loop       (loop),
        .stop       (stop),
        .x          (x),
        .x_valid    (x_valid),
        .busy       (busy),
        .frame_done (frame_done),
        .err        (err),
        .frame_cnt  (frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic pulse_start(input logic [W-1:0] p, input logic [LW-1:0] l,
                               input logic [7:0] g, input logic lp);
        @(posedge clk);
        #1;
        pattern = p;
        len     = l;
        gap     = g;
        loop    = lp;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [W-1:0] p42;
        logic [3:0]   p4;
        p42 = 42'b0100_1100_0111_0000_1111_0000_0111_1100_0000_1111_11;
        p4  = 4'b1011;

        rst = 1'b0; start = 1'b0; pattern = '0; len = '0; gap = '0; loop = 1'b0; stop = 1'b0;
        #3;
        check("rst_x", x, 0);
        check("rst_xv", x_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_fd", frame_done, 0);
        check("rst_err", err, 0);
        check("rst_cnt", frame_cnt, 0);
        #10 rst = 1'b1;

        // 42-bit frame, no gap
        pulse_start(p42, 6'd42, 8'd0, 1'b0);
        for (int i = W - 1; i >= 0; i--) begin
            @(negedge clk);
            check("f42_x", x, p42[i]);
            check("f42_xv", x_valid, 1);
            check("f42_fd", frame_done, (i == 0));
        end
        @(negedge clk);
        check("f42_busy_end", busy, 0);
        check("f42_xv_end", x_valid, 0);
        check("f42_cnt", frame_cnt, 1);

        // 4-bit frame with gap of 3
        pulse_start({38'b0, p4}, 6'd4, 8'd3, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("g3_xv", x_valid, 0);
            check("g3_x", x, 0);
            check("g3_busy", busy, 1);
        end
        for (int i = 3; i >= 0; i--) begin
            @(negedge clk);
            check("g3_bit", x, p4[i]);
            check("g3_bit_xv", x_valid, 1);
            check("g3_fd", frame_done, (i == 0));
        end
        @(negedge clk);
        check("g3_busy_end", busy, 0);
        check("g3_cnt", frame_cnt, 1);

        // looping 2'b10 with gap 1, stop during bit-1 of frame 4
        pulse_start(42'b10, 6'd2, 8'd1, 1'b1);
        for (int f = 0; f < 3; f++) begin
            @(negedge clk);
            check("lp_gap_xv", x_valid, 0);
            check("lp_gap_busy", busy, 1);
            @(negedge clk);
            check("lp_b1", x, 1);
            check("lp_b1_xv", x_valid, 1);
            @(negedge clk);
            check("lp_b0", x, 0);
            check("lp_b0_fd", frame_done, 1);
            check("lp_cnt", frame_cnt, f);
        end
        @(negedge clk);
        check("lp_gap4_xv", x_valid, 0);
        @(negedge clk);
        check("lp_b1_4", x, 1);
        stop = 1'b1;
        @(posedge clk);
        #1 stop = 1'b0;
        @(negedge clk);
        check("lp_b0_4", x, 0);
        check("lp_fd_4", frame_done, 1);
        @(negedge clk);
        check("lp_end_busy", busy, 0);
        check("lp_end_xv", x_valid, 0);
        check("lp_end_cnt", frame_cnt, 4);
        @(negedge clk);
        check("lp_idle_busy", busy, 0);

        // rejected starts
        pulse_start({38'b0, p4}, 6'd0, 8'd0, 1'b0);
        @(negedge clk);
        check("len0_err", err, 1);
        check("len0_busy", busy, 0);
        @(negedge clk);
        check("len0_err_clr", err, 0);
        pulse_start({38'b0, p4}, 6'd43, 8'd0, 1'b0);
        @(negedge clk);
        check("len43_err", err, 1);
        check("len43_busy", busy, 0);
        check("len43_cnt", frame_cnt, 4);
        @(negedge clk);
        check("len43_err_clr", err, 0);

        // start during SEND must not disturb the stream
        pulse_start({38'b0, p4}, 6'd4, 8'd0, 1'b0);
        @(negedge clk);
        check("ign_b3", x, 1);
        start = 1'b1; pattern = '1; len = 6'd1; gap = 8'd5;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        check("ign_b2", x, 0);
        @(negedge clk);
        check("ign_b1", x, 1);
        check("ign_fd1", frame_done, 0);
        @(negedge clk);
        check("ign_b0", x, 1);
        check("ign_fd0", frame_done, 1);
        @(negedge clk);
        check("ign_busy", busy, 0);
        check("ign_cnt", frame_cnt, 1);

        // len=1 continuous loop, 300 frames, counter wrap
        pulse_start(42'b1, 6'd1, 8'd0, 1'b1);
        for (int k = 1; k <= 300; k++) begin
            @(negedge clk);
            check("one_x", x, 1);
            check("one_fd", frame_done, 1);
            check("one_cnt", frame_cnt, (k - 1) % 256);
        end
        stop = 1'b1;
        @(posedge clk);
        #1 stop = 1'b0;
        @(negedge clk);
        check("one_busy_end", busy, 0);
        check("one_fd_end", frame_done, 0);
        check("one_cnt_end", frame_cnt, 44);

        // asynchronous reset mid-frame, then immediate restart
        pulse_start(42'b11, 6'd2, 8'd0, 1'b1);
        repeat (5) @(negedge clk);
        check("ar_pre_xv", x_valid, 1);
        check("ar_pre_cnt", frame_cnt, 2);
        rst = 1'b0;
        #1;
        check("ar_x", x, 0);
        check("ar_xv", x_valid, 0);
        check("ar_busy", busy, 0);
        check("ar_fd", frame_done, 0);
        check("ar_cnt", frame_cnt, 0);
        #1;
        rst = 1'b1;
        pattern = {38'b0, p4}; len = 6'd4; gap = 8'd0; loop = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int i = 3; i >= 0; i--) begin
            @(negedge clk);
            check("rs_bit", x, p4[i]);
            check("rs_xv", x_valid, 1);
        end
        @(negedge clk);
        check("rs_cnt", frame_cnt, 1);
        check("rs_busy", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
